// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter that picks one functional-unit result per cycle and
// broadcasts it on the common data bus one cycle later.
//
// Optional feature macro: CDB_ARB_PERF_EN (adds grant_cnt / conflict_cnt).
//
// Ports
//   clk          : clock, all state on rising edge
//   rst          : synchronous reset, active low
//   flush        : ROB flush, suppresses acceptance this cycle
//   req_valid    : per-unit result valid            [NUM_REQ]
//   req_data     : per-unit 32-bit result           [NUM_REQ*32]
//   req_tag      : per-unit ROB tag                 [NUM_REQ*TAG_W]
//   req_ready    : one-hot grant (combinational)    [NUM_REQ]
//   cdb_valid    : broadcast valid (registered)
//   cdb_data     : broadcast result (registered)
//   cdb_tag      : broadcast ROB tag (registered)
//   cdb_src      : producing unit index (registered)
//   grant_cnt    : saturating acceptance count      (CDB_ARB_PERF_EN only)
//   conflict_cnt : saturating contention count      (CDB_ARB_PERF_EN only)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*32-1:0]    req_data,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     cdb_valid,
    output logic [31:0]              cdb_data,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [SRC_W-1:0]         cdb_src
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]              grant_cnt,
    output logic [31:0]              conflict_cnt
`endif
);

    localparam int unsigned DATA_W = 32;

    logic [SRC_W-1:0]   r_rr_ptr;
    logic               r_cdb_valid;
    logic [DATA_W-1:0]  r_cdb_data;
    logic [TAG_W-1:0]   r_cdb_tag;
    logic [SRC_W-1:0]   r_cdb_src;

    logic [DATA_W-1:0]  w_data_arr [NUM_REQ];
    logic [TAG_W-1:0]   w_tag_arr  [NUM_REQ];
    logic               w_found;
    logic               w_accept;
    logic [SRC_W-1:0]   w_gnt_idx;
    logic [SRC_W-1:0]   w_idx;
    logic [SRC_W-1:0]   w_next_ptr;
    logic [NUM_REQ-1:0] w_onehot;
    int                 w_sum;

    // Unpack the flat request buses into per-unit views
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_data_arr[i] = req_data[DATA_W*i +: DATA_W];
        assign w_tag_arr[i]  = req_tag[TAG_W*i +: TAG_W];
    end

    // Round-robin search: walk from the farthest slot back to rr_ptr so the
    // nearest valid unit (in wrap order) is the last and winning assignment
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        w_sum     = 0;
        w_onehot  = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            w_sum = int'(r_rr_ptr) + k;
            if (w_sum >= int'(NUM_REQ)) begin
                w_sum = w_sum - int'(NUM_REQ);
            end
            w_idx = SRC_W'(w_sum);
            if (req_valid[w_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
        if (w_found) begin
            w_onehot[w_gnt_idx] = 1'b1;
        end
    end

    // Reset and flush both veto the grant
    assign w_accept   = w_found & ~flush & rst;
    assign req_ready  = w_accept ? w_onehot : '0;
    assign w_next_ptr = (w_gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0
                                                           : w_gnt_idx + SRC_W'(1);

    // Broadcast register and pointer update; payload holds when idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr    <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_data  <= '0;
            r_cdb_tag   <= '0;
            r_cdb_src   <= '0;
        end else begin
            r_cdb_valid <= w_accept;
            if (w_accept) begin
                r_rr_ptr   <= w_next_ptr;
                r_cdb_data <= w_data_arr[w_gnt_idx];
                r_cdb_tag  <= w_tag_arr[w_gnt_idx];
                r_cdb_src  <= w_gnt_idx;
            end
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_data  = r_cdb_data;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_src   = r_cdb_src;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] r_grant_cnt;
    logic [31:0] r_conflict_cnt;
    logic        w_multi;

    // Two or more bits set <=> clearing the lowest set bit leaves something
    assign w_multi = |(req_valid & (req_valid - NUM_REQ'(1)));

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grant_cnt    <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_accept && (r_grant_cnt != 32'hFFFF_FFFF)) begin
                r_grant_cnt <= r_grant_cnt + 32'd1;
            end
            if (w_multi && !flush && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end

    assign grant_cnt    = r_grant_cnt;
    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed self-checking bench for cdb_arbiter (NUM_REQ=4, TAG_W=3).
// Inputs are driven 1 time unit after the rising edge; combinational grants
// are checked 1 unit later and registered outputs 1 unit after the next edge.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned SRC_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*32-1:0]    req_data;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     cdb_valid;
    logic [31:0]              cdb_data;
    logic [TAG_W-1:0]         cdb_tag;
    logic [SRC_W-1:0]         cdb_src;
`ifdef CDB_ARB_PERF_EN
    logic [31:0]              grant_cnt;
    logic [31:0]              conflict_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    cdb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W),
        .SRC_W   (SRC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_tag      (req_tag),
        .req_ready    (req_ready),
        .cdb_valid    (cdb_valid),
        .cdb_data     (cdb_data),
        .cdb_tag      (cdb_tag),
        .cdb_src      (cdb_src)
`ifdef CDB_ARB_PERF_EN
        ,
        .grant_cnt    (grant_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance to 1 unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational logic settle after driving inputs
    task automatic settle();
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_tag   = '0;
        // Unit i carries data 0x1000_0000+i and tag i unless overridden
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[32*i +: 32]     = 32'h1000_0000 + 32'(i);
            req_tag[TAG_W*i +: TAG_W] = TAG_W'(i);
        end

        // ---- reset state ----
        tick();
        tick();
        req_valid = 4'b1111;
        settle();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(cdb_valid), 32'h0);
        check("rst_data",  cdb_data,       32'h0);
        check("rst_tag",   32'(cdb_tag),   32'h0);
        check("rst_src",   32'(cdb_src),   32'h0);
        tick();

        // ---- release; single request on unit 2 ----
        rst       = 1'b1;
        req_valid = '0;
        tick();
        req_valid = 4'b0100;
        req_data[32*2 +: 32]      = 32'hDEAD_BEEF;
        req_tag[TAG_W*2 +: TAG_W] = 3'd5;
        settle();
        check("u2_ready", 32'(req_ready), 32'h4);
        tick();
        check("u2_valid", 32'(cdb_valid), 32'h1);
        check("u2_data",  cdb_data,       32'hDEAD_BEEF);
        check("u2_tag",   32'(cdb_tag),   32'h5);
        check("u2_src",   32'(cdb_src),   32'h2);
        req_data[32*2 +: 32]      = 32'h1000_0002;
        req_tag[TAG_W*2 +: TAG_W] = 3'd2;

        // ---- idle cycle: valid drops, payload holds (rr_ptr now 3) ----
        req_valid = '0;
        settle();
        check("idle_ready", 32'(req_ready), 32'h0);
        tick();
        check("idle_valid", 32'(cdb_valid), 32'h0);
        check("idle_data",  cdb_data,       32'hDEAD_BEEF);
        check("idle_src",   32'(cdb_src),   32'h2);

        // ---- wrap-around: rr_ptr=3, valid 1001 -> 3 then 0 ----
        req_valid = 4'b1001;
        settle();
        check("wrap_ready0", 32'(req_ready), 32'h8);
        tick();
        check("wrap_src0",  32'(cdb_src),  32'h3);
        check("wrap_data0", cdb_data,      32'h1000_0003);
        settle();
        check("wrap_ready1", 32'(req_ready), 32'h1);
        tick();
        check("wrap_valid1", 32'(cdb_valid), 32'h1);
        check("wrap_src1",   32'(cdb_src),   32'h0);

        // ---- flush (rr_ptr=1): registered broadcast stays visible ----
        flush     = 1'b1;
        req_valid = 4'b0011;
        settle();
        check("flush_ready",   32'(req_ready), 32'h0);
        check("flush_nortro",  32'(cdb_valid), 32'h1);
        tick();
        check("flush_valid",   32'(cdb_valid), 32'h0);
        check("flush_src_hold", 32'(cdb_src),  32'h0);
        flush = 1'b0;
        settle();
        check("postflush_ready", 32'(req_ready), 32'h2);
        tick();
        check("postflush_src", 32'(cdb_src), 32'h1);

        // ---- bring rr_ptr to 0 via a grant on unit 3 (rr_ptr=2) ----
        req_valid = 4'b1000;
        tick();
        check("align_src", 32'(cdb_src), 32'h3);

        // ---- all four valid for 8 cycles: 0,1,2,3,0,1,2,3 ----
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            settle();
            check("rr_ready", 32'(req_ready), 32'(4'b0001 << (i % 4)));
            tick();
            check("rr_valid", 32'(cdb_valid), 32'h1);
            check("rr_src",   32'(cdb_src),   32'(i % 4));
            check("rr_tag",   32'(cdb_tag),   32'(i % 4));
            check("rr_data",  cdb_data,       32'h1000_0000 + 32'(i % 4));
        end

        // ---- single requester held continuously: granted every cycle ----
        req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", 32'(cdb_valid), 32'h1);
            check("hold_src",   32'(cdb_src),   32'h1);
        end

        // ---- reset mid-operation (rr_ptr=2): grant unit 0, then reset ----
        req_valid = 4'b0001;
        tick();
        check("prerst_valid", 32'(cdb_valid), 32'h1);
        rst       = 1'b0;
        req_valid = 4'b1111;
        settle();
        check("midrst_ready", 32'(req_ready), 32'h0);
        tick();
        check("midrst_valid", 32'(cdb_valid), 32'h0);
        check("midrst_data",  cdb_data,       32'h0);
        check("midrst_src",   32'(cdb_src),   32'h0);
`ifdef CDB_ARB_PERF_EN
        check("rst_grant_cnt",    grant_cnt,    32'h0);
        check("rst_conflict_cnt", conflict_cnt, 32'h0);
`endif
        rst = 1'b1;
        settle();
        check("postrst_ready", 32'(req_ready), 32'h1);
        tick();
        check("postrst_src", 32'(cdb_src), 32'h0);

`ifdef CDB_ARB_PERF_EN
        // ---- counters: 5 contended cycles then 2 idle ----
        rst       = 1'b0;
        req_valid = '0;
        tick();
        rst       = 1'b1;
        req_valid = 4'b0110;
        for (int i = 0; i < 5; i++) tick();
        req_valid = '0;
        tick();
        tick();
        check("perf_grant_cnt",    grant_cnt,    32'd5);
        check("perf_conflict_cnt", conflict_cnt, 32'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
